// File: rtl/cache_fill_ctrl_if.sv
// Request, response, writeback and fill signals between the cache pipeline,
// the fill controller and the memory side.
interface cache_fill_ctrl_if #(
    parameter int IDX_W = 2,
    parameter int TAG_W = 8
);
    logic             req_vld;
    logic             req_rdy;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_wr;

    logic             resp_vld;
    logic             resp_hit;
    logic [1:0]       resp_way;

    logic             wb_vld;
    logic             wb_rdy;
    logic [IDX_W-1:0] wb_idx;
    logic [TAG_W-1:0] wb_tag;
    logic [1:0]       wb_way;

    logic             fill_vld;
    logic             fill_rdy;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [1:0]       fill_way;
    logic             fill_done;

    // Environment side: issues lookups and plays the memory.
    modport master (
        output req_vld, req_idx, req_tag, req_wr, wb_rdy, fill_rdy, fill_done,
        input  req_rdy, resp_vld, resp_hit, resp_way,
               wb_vld, wb_idx, wb_tag, wb_way,
               fill_vld, fill_idx, fill_tag, fill_way
    );

    // Controller side.
    modport slave (
        input  req_vld, req_idx, req_tag, req_wr, wb_rdy, fill_rdy, fill_done,
        output req_rdy, resp_vld, resp_hit, resp_way,
               wb_vld, wb_idx, wb_tag, wb_way,
               fill_vld, fill_idx, fill_tag, fill_way
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Replacement and miss sequencer for a 3-way set-associative cache: keeps
// tag/valid/dirty/matrix-LRU per set, answers lookups, runs writeback and fill.
module cache_fill_ctrl #(
    parameter int  SETS  = 4,
    parameter int  TAG_W = 8,
    localparam int IDX_W = $clog2(SETS)
) (
    input logic              clk,
    input logic              clr,
    cache_fill_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_e;

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [TAG_W-1:0]                 cap_tag_q, cap_tag_d;
    logic                             wr_q, wr_d;
    logic [1:0]                       way_q, way_d;
    logic                             hit_q, hit_d;
    logic [SETS-1:0][2:0][TAG_W-1:0]  tags_q, tags_d;
    logic [SETS-1:0][2:0]             valid_q, valid_d;
    logic [SETS-1:0][2:0]             dirty_q, dirty_d;
    logic [SETS-1:0][8:0]             lru_q, lru_d;

    logic       hit;
    logic [1:0] hit_way;
    logic [1:0] victim;

    // Field i (bits 3i+2:3i) bit j set: way i used more recently than way j.
    function automatic logic [8:0] lru_touch(input logic [8:0] lru, input logic [1:0] k);
        logic [8:0] r;
        r = lru;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i == int'(k)) begin
                    r[3*i+j] = (j != i);
                end else if (j == int'(k)) begin
                    r[3*i+j] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] lru_way(input logic [8:0] lru);
        if (lru[8:6] == 3'b000) begin
            return 2'd2;
        end else if (lru[5:3] == 3'b000) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 2; w >= 0; w--) begin
            if (valid_q[idx_q][w] && (tags_q[idx_q][w] == cap_tag_q)) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    always_comb begin
        if (!valid_q[idx_q][0]) begin
            victim = 2'd0;
        end else if (!valid_q[idx_q][1]) begin
            victim = 2'd1;
        end else if (!valid_q[idx_q][2]) begin
            victim = 2'd2;
        end else begin
            victim = lru_way(lru_q[idx_q]);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_tag_d = cap_tag_q;
        wr_d      = wr_q;
        way_d     = way_q;
        hit_d     = hit_q;
        tags_d    = tags_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        lru_d     = lru_q;

        case (state_q)
            IDLE: begin
                if (bus.req_vld) begin
                    idx_d     = bus.req_idx;
                    cap_tag_d = bus.req_tag;
                    wr_d      = bus.req_wr;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    lru_d[idx_q]            = lru_touch(lru_q[idx_q], hit_way);
                    dirty_d[idx_q][hit_way] = dirty_q[idx_q][hit_way] | wr_q;
                    hit_d                   = 1'b1;
                    way_d                   = hit_way;
                    state_d                 = RESP;
                end else begin
                    hit_d = 1'b0;
                    way_d = victim;
                    if (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) begin
                        state_d = WB_REQ;
                    end else begin
                        state_d = FILL_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (bus.wb_rdy) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (bus.fill_rdy) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                // Install only once the data is in; an abort before this leaves the set untouched.
                if (bus.fill_done) begin
                    tags_d[idx_q][way_q]  = cap_tag_q;
                    valid_d[idx_q][way_q] = 1'b1;
                    dirty_d[idx_q][way_q] = wr_q;
                    lru_d[idx_q]          = lru_touch(lru_q[idx_q], way_q);
                    hit_d                 = 1'b0;
                    state_d               = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_tag_q <= '0;
            wr_q      <= 1'b0;
            way_q     <= 2'd0;
            hit_q     <= 1'b0;
            tags_q    <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            lru_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_tag_q <= cap_tag_d;
            wr_q      <= wr_d;
            way_q     <= way_d;
            hit_q     <= hit_d;
            tags_q    <= tags_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            lru_q     <= lru_d;
        end
    end

    assign bus.req_rdy  = (state_q == IDLE);
    assign bus.resp_vld = (state_q == RESP);
    assign bus.resp_hit = hit_q;
    assign bus.resp_way = way_q;

    assign bus.wb_vld   = (state_q == WB_REQ);
    assign bus.wb_idx   = idx_q;
    assign bus.wb_tag   = tags_q[idx_q][way_q];
    assign bus.wb_way   = way_q;

    assign bus.fill_vld = (state_q == FILL_REQ);
    assign bus.fill_idx = idx_q;
    assign bus.fill_tag = cap_tag_q;
    assign bus.fill_way = way_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a vector table of lookups with
// hand-computed results, plus sequences for reset abort and busy-time inputs.
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.IDX_W(2), .TAG_W(8)) bus ();

    cache_fill_ctrl #(.SETS(4), .TAG_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] idx;
        logic [7:0] tag;
        logic       wr;
        int         hold;
        logic       exp_hit;
        logic [1:0] exp_way;
        logic       exp_wb;
        logic [7:0] exp_wb_tag;
        logic [1:0] exp_wb_way;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int tests    = 0;
    int failures = 0;

    logic       r_hit, r_wb, r_fill, r_pulse_ok, r_abort;
    logic [1:0] r_way, r_wb_way, r_wb_idx, r_fill_idx, r_fill_way;
    logic [7:0] r_wb_tag, r_fill_tag;
    int         r_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One lookup with an always-ready memory (wb_rdy delayed by 'hold' cycles).
    // With 'abort' set, clr is pulled low on the first FILL_WAIT cycle instead of fill_done.
    task automatic do_req(input logic [1:0] idx, input logic [7:0] tag, input logic wr,
                          input int hold, input bit abort);
        int  n;
        int  h;
        bit  fill_pend;
        r_hit = 0; r_way = 0; r_wb = 0; r_wb_tag = 0; r_wb_way = 0; r_wb_idx = 0;
        r_fill = 0; r_fill_idx = 0; r_fill_tag = 0; r_fill_way = 0; r_pulse_ok = 0; r_abort = 0;
        h = hold;
        fill_pend = 0;
        @(negedge clk);
        bus.req_vld = 1'b1;
        bus.req_idx = idx;
        bus.req_tag = tag;
        bus.req_wr  = wr;
        n = 0;
        while (!bus.req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_vld = 1'b0;
        r_lat = 0;
        while (r_lat < 200) begin
            @(negedge clk);
            r_lat++;
            bus.fill_done = 1'b0;
            if (bus.resp_vld) break;
            bus.wb_rdy   = 1'b0;
            bus.fill_rdy = 1'b0;
            if (fill_pend) begin
                fill_pend = 0;
                if (abort) begin
                    clr = 1'b0;
                    r_abort = 1;
                    break;
                end
                bus.fill_done = 1'b1;
            end
            if (bus.wb_vld) begin
                if (!r_wb) begin
                    r_wb_tag = bus.wb_tag;
                    r_wb_way = bus.wb_way;
                    r_wb_idx = bus.wb_idx;
                end else begin
                    chk("wb_tag_stable", bus.wb_tag, r_wb_tag);
                    chk("wb_way_stable", bus.wb_way, r_wb_way);
                    chk("wb_idx_stable", bus.wb_idx, r_wb_idx);
                    chk("wb_busy_rdy", bus.req_rdy, 0);
                    chk("wb_no_fill", bus.fill_vld, 0);
                end
                r_wb = 1;
                if (h > 0) h--;
                else bus.wb_rdy = 1'b1;
            end
            if (bus.fill_vld) begin
                r_fill     = 1;
                r_fill_idx = bus.fill_idx;
                r_fill_tag = bus.fill_tag;
                r_fill_way = bus.fill_way;
                bus.fill_rdy = 1'b1;
                fill_pend    = 1;
            end
        end
        if (!r_abort) begin
            chk("resp_timeout", (r_lat < 200), 1);
            r_hit = bus.resp_hit;
            r_way = bus.resp_way;
            @(negedge clk);
            r_pulse_ok = !bus.resp_vld;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{2'd0, 8'h11, 1'b0, 0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[1]  = '{2'd0, 8'h22, 1'b1, 0, 1'b0, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[2]  = '{2'd0, 8'h33, 1'b0, 0, 1'b0, 2'd2, 1'b0, 8'h00, 2'd0};
        vec[3]  = '{2'd0, 8'h11, 1'b0, 0, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[4]  = '{2'd0, 8'h44, 1'b0, 5, 1'b0, 2'd1, 1'b1, 8'h22, 2'd1};
        vec[5]  = '{2'd0, 8'h33, 1'b0, 0, 1'b1, 2'd2, 1'b0, 8'h00, 2'd0};
        vec[6]  = '{2'd0, 8'h55, 1'b1, 0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[7]  = '{2'd0, 8'h44, 1'b1, 0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[8]  = '{2'd0, 8'h66, 1'b0, 0, 1'b0, 2'd2, 1'b0, 8'h00, 2'd0};
        vec[9]  = '{2'd0, 8'h77, 1'b0, 0, 1'b0, 2'd0, 1'b1, 8'h55, 2'd0};
        vec[10] = '{2'd1, 8'h11, 1'b0, 0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[11] = '{2'd0, 8'h44, 1'b0, 0, 1'b1, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[12] = '{2'd2, 8'h00, 1'b0, 0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[13] = '{2'd2, 8'hFF, 1'b1, 0, 1'b0, 2'd1, 1'b0, 8'h00, 2'd0};
        vec[14] = '{2'd2, 8'h00, 1'b0, 0, 1'b1, 2'd0, 1'b0, 8'h00, 2'd0};
        vec[15] = '{2'd3, 8'hAA, 1'b0, 0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0};

        bus.req_vld = 0; bus.req_idx = 0; bus.req_tag = 0; bus.req_wr = 0;
        bus.wb_rdy = 0; bus.fill_rdy = 0; bus.fill_done = 0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", bus.req_rdy, 1);
        chk("rst_resp_vld", bus.resp_vld, 0);
        chk("rst_wb_vld", bus.wb_vld, 0);
        chk("rst_fill_vld", bus.fill_vld, 0);
        chk("rst_wb_tag", bus.wb_tag, 0);
        chk("rst_fill_tag", bus.fill_tag, 0);
        clr = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(vec[i].idx, vec[i].tag, vec[i].wr, vec[i].hold, 0);
            chk($sformatf("v%0d_hit", i), r_hit, vec[i].exp_hit);
            chk($sformatf("v%0d_way", i), r_way, vec[i].exp_way);
            chk($sformatf("v%0d_wb_seen", i), r_wb, vec[i].exp_wb);
            chk($sformatf("v%0d_pulse", i), r_pulse_ok, 1);
            if (vec[i].exp_wb) begin
                chk($sformatf("v%0d_wb_tag", i), r_wb_tag, vec[i].exp_wb_tag);
                chk($sformatf("v%0d_wb_way", i), r_wb_way, vec[i].exp_wb_way);
                chk($sformatf("v%0d_wb_idx", i), r_wb_idx, vec[i].idx);
            end
            if (vec[i].exp_hit) begin
                chk($sformatf("v%0d_hit_lat", i), r_lat, 1);
                chk($sformatf("v%0d_no_fill", i), r_fill, 0);
            end else begin
                chk($sformatf("v%0d_fill_seen", i), r_fill, 1);
                chk($sformatf("v%0d_fill_idx", i), r_fill_idx, vec[i].idx);
                chk($sformatf("v%0d_fill_tag", i), r_fill_tag, vec[i].tag);
                chk($sformatf("v%0d_fill_way", i), r_fill_way, vec[i].exp_way);
            end
        end

        // Reset during FILL_WAIT abandons the install.
        do_req(2'd1, 8'h55, 1'b0, 0, 1);
        chk("abort_reached", r_abort, 1);
        @(negedge clk);
        chk("abort_rdy_in_rst", bus.req_rdy, 1);
        chk("abort_resp_in_rst", bus.resp_vld, 0);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_rdy", bus.req_rdy, 1);
        chk("abort_resp", bus.resp_vld, 0);
        do_req(2'd1, 8'h55, 1'b0, 0, 0);
        chk("abort_relook_hit", r_hit, 0);
        chk("abort_relook_way", r_fill_way, 0);
        do_req(2'd0, 8'h44, 1'b0, 0, 0);
        chk("abort_set0_cleared", r_hit, 0);
        chk("abort_set0_way", r_way, 0);

        // fill_done while idle is ignored.
        @(negedge clk);
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        chk("idle_done_resp", bus.resp_vld, 0);
        chk("idle_done_rdy", bus.req_rdy, 1);
        @(negedge clk);
        chk("idle_done_resp2", bus.resp_vld, 0);
        do_req(2'd1, 8'h55, 1'b0, 0, 0);
        chk("idle_done_hit", r_hit, 1);
        chk("idle_done_way", r_way, 0);

        // Request held while busy; stray fill_done in FILL_REQ and with the fill handshake.
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_idx = 2'd2; bus.req_tag = 8'h12; bus.req_wr = 1'b0;
        @(negedge clk);
        bus.req_wr = 1'b1;
        chk("busy_rdy_lookup", bus.req_rdy, 0);
        @(negedge clk);
        chk("busy_fill_vld", bus.fill_vld, 1);
        chk("busy_rdy_fillreq", bus.req_rdy, 0);
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        chk("busy_still_fillreq", bus.fill_vld, 1);
        chk("busy_no_resp", bus.resp_vld, 0);
        bus.fill_rdy = 1'b1;
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_rdy = 1'b0;
        bus.fill_done = 1'b0;
        chk("busy_fillwait_vld", bus.fill_vld, 0);
        chk("busy_sameedge_done", bus.resp_vld, 0);
        @(negedge clk);
        chk("busy_wait_resp", bus.resp_vld, 0);
        chk("busy_wait_rdy", bus.req_rdy, 0);
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        chk("busy_resp_vld", bus.resp_vld, 1);
        chk("busy_resp_hit", bus.resp_hit, 0);
        chk("busy_resp_way", bus.resp_way, 0);
        chk("busy_rdy_resp", bus.req_rdy, 0);
        @(negedge clk);
        chk("busy_idle_rdy", bus.req_rdy, 1);
        chk("busy_idle_resp", bus.resp_vld, 0);
        @(negedge clk);
        bus.req_vld = 1'b0;
        chk("second_lookup_rdy", bus.req_rdy, 0);
        @(negedge clk);
        chk("second_resp_vld", bus.resp_vld, 1);
        chk("second_resp_hit", bus.resp_hit, 1);
        chk("second_resp_way", bus.resp_way, 0);
        @(negedge clk);
        chk("second_pulse_end", bus.resp_vld, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Per-set replacement and miss sequencer for a 3-way set-associative cache.
- Holds tag, valid, dirty and 9-bit matrix pseudo-LRU state for every set, and answers lookups with hit or miss.
- On a miss it selects a victim, writes it back if it is dirty, requests the fill, and installs the new line.
- Sits between the cache pipeline (request side) and the memory interface (writeback/fill side).

Parameters:
SETS, 4, number of sets; IDX_W = log2(SETS)
TAG_W, 8, tag width

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-low reset
req_vld  in  1  lookup request valid
req_rdy  out  1  controller idle, can accept a request
req_idx  in  IDX_W  set index
req_tag  in  TAG_W  tag
req_wr  in  1  access is a store; line becomes dirty
resp_vld  out  1  one-cycle response pulse
resp_hit  out  1  1 = hit, 0 = miss serviced
resp_way  out  2  way hit or installed (0..2)
wb_vld  out  1  writeback request
wb_rdy  in  1  memory accepts writeback
wb_idx  out  IDX_W  writeback set
wb_tag  out  TAG_W  victim tag
wb_way  out  2  victim way
fill_vld  out  1  fill request
fill_rdy  in  1  memory accepts fill request
fill_idx  out  IDX_W  fill set
fill_tag  out  TAG_W  requested tag
fill_way  out  2  destination way
fill_done  in  1  fill data written; one-cycle pulse

Behaviour:

Clock and reset:
- Clock is clk; reset is clr, asynchronous and active-low.
- While clr=0: all valid, dirty and LRU bits = 0; tags = 0; FSM = IDLE.
- Reset values of outputs: req_rdy=1; all other outputs 0.
- Reset in any state abandons the operation; no install, no LRU change.

LRU encoding, per set, 9 bits:
- Field f[i] = bits[3i+2:3i]. Bit j of f[i] = 1 means way i was used more recently than way j. The diagonal bit is always 0.
- Touch way k: f[k] = all ones except bit k; clear bit k in each other field.
- LRU way = first way with f == 000, checked in priority order way2, way1, way0. The reset state selects way2.

Victim selection:
- Lowest-index invalid way if any way is invalid; otherwise the LRU way.

Request acceptance:
- req_rdy = (state == IDLE).
- A request is accepted on a clk edge with req_vld & req_rdy. idx, tag and wr are captured in registers.

FSM:
- IDLE -> LOOKUP on accept.
- LOOKUP, one cycle: compare the captured tag against the valid ways of the set.
  - Hit way h: touch h, dirty[h] |= wr, latch resp_hit=1 and resp_way=h -> RESP.
  - Miss: latch the victim v. If v is valid and dirty -> WB_REQ, else -> FILL_REQ.
- WB_REQ: wb_vld=1 with wb_idx, wb_tag = old tag[v], wb_way = v, all stable until wb_rdy. On wb_vld & wb_rdy -> FILL_REQ.
- FILL_REQ: fill_vld=1 with captured idx, tag and fill_way = v, stable until fill_rdy. On fill_vld & fill_rdy -> FILL_WAIT.
- FILL_WAIT: wait for fill_done. On fill_done: tag[v] = tag, valid[v] = 1, dirty[v] = wr, touch v, resp_hit = 0, resp_way = v -> RESP.
- RESP: resp_vld=1 for exactly one cycle (no backpressure) -> IDLE.

Latency:
- Hit: accept edge, then resp_vld high in the 2nd cycle after the accept edge.
- Miss: depends on the handshakes; minimum 4 cycles plus fill latency.

Boundary rules:
- fill_done outside FILL_WAIT is ignored.
- wb_rdy and fill_rdy are ignored when the matching vld is low.
- req_vld while busy is not accepted; the requester holds it.
- fill_done arriving in the same cycle as fill_rdy acceptance is ignored; it must come after FILL_WAIT is entered.
- State for other sets is never modified.
- A miss never selects a way that hit.

Test Plan:
1. After reset, request idx0 tag 0x11 wr=0 -> miss, victim way0, no wb_vld; fill_vld with idx0, tag 0x11, way0; after fill_done, resp_vld with hit=0, way=0.
2. Fill set0 with tags 0x11 (way0), 0x22 (way1, wr=1), 0x33 (way2), then look up 0x11 -> resp_vld 2 cycles after accept with hit=1, way0. Set0 LRU = f0=110, f1=000, f2=010; the LRU way is way1.
3. Continue from scenario 2: request 0x44 -> wb_vld with wb_idx=0, wb_tag=0x22, wb_way=1, then fill to way1; the resulting resp has hit=0, way=1.
4. Hold wb_rdy low 5 cycles in scenario 3 -> wb_vld and its fields stay stable, req_rdy stays 0, and fill_vld stays 0 until the handshake.
5. Drive clr low during FILL_WAIT for set1 tag 0x55, then release -> req_rdy=1; a lookup of 0x55 in set1 misses and selects way0.
6. Pulse fill_done while in IDLE, and issue req_vld during FILL_REQ -> no state change, and the second request is accepted only after RESP.
